mandel_scan_ctrl: RTL
=====================

# mandel_scan_ctrl

Parametrised raster/escape-time controller for the FPGA Mandelbrot renderer. It owns the x/y pixel counters and the per-pixel iteration counter, and sequences the fixed-point z/c datapath through init and step cycles. When a pixel escapes or reaches the run-time iteration cap, it presents the pixel to the framebuffer/VGA writer over a valid/ready handshake. It replaces the hard-coded control FSM and its external i/j/n counters.

## Interface
Parameters:
- WIDTH, 160: pixels per row.
- HEIGHT, 120: rows per frame.
- XW, $clog2(WIDTH): x coordinate width.
- YW, $clog2(HEIGHT): y coordinate width.
- ITERW, 8: iteration counter and colour width.

Ports:
- clk, in, 1: the only clock; all logic on posedge.
- rst, in, 1: asynchronous, active-low reset.
- start, in, 1: frame request; sampled only in IDLE and DONE.
- max_iter, in, ITERW: iteration cap; captured on accepted start.
- dp_row, out, 1: datapath loads the row's imaginary part from py.
- dp_init, out, 1: datapath loads c from px/py and sets z=0.
- dp_step, out, 1: datapath advances z one iteration.
- dp_escaped, in, 1: combinational |z|²>4 for the current z registers.
- px, out, XW: current pixel x.
- py, out, YW: current pixel y.
- pcolour, out, ITERW: iteration count of the presented pixel.
- in_set, out, 1: presented pixel hit the cap without escaping.
- plot_valid, out, 1: pixel presented to the writer.
- plot_ready, in, 1: writer accepts.
- busy, out, 1: high in every state except IDLE and DONE.
- done, out, 1: frame complete; held high in DONE.

## Operation
- States: IDLE, ROW, PIX, ITER, PLOT, NEXT, DONE.
- IDLE:
  - start=1: capture max_iter into miter, px=0, py=0, go to ROW.
  - Otherwise stay.
- ROW: dp_row=1 for one cycle, then PIX.
- PIX: dp_init=1, n=0 for one cycle, then ITER.
- ITER, evaluated each cycle, first match wins:
  - dp_escaped=1: go to PLOT with pcolour=n, in_set=0.
  - n==miter: go to PLOT with pcolour=n, in_set=1.
  - Otherwise: dp_step=1, n=n+1, stay.
- Escape has priority over the cap on the same cycle.
- PLOT:
  - plot_valid=1; px, py, pcolour and in_set are held stable until plot_ready=1.
  - On handshake with px==WIDTH-1: go to NEXT.
  - On other handshakes: px=px+1, go to PIX.
- NEXT:
  - py==HEIGHT-1: go to DONE.
  - Otherwise: py=py+1, px=0, go to ROW.
- DONE:
  - done=1.
  - start=1: recapture max_iter, px=0, py=0, go to ROW, so back-to-back frames need no IDLE visit.
- miter=0: every pixel plots with pcolour=0. in_set=1 unless dp_escaped is already high in the first ITER cycle.
- Counters never exceed WIDTH-1 or HEIGHT-1. n never exceeds miter, so there is no wrap.
- Outputs other than those listed for a state are 0.

## Timing
- Reset values: state IDLE, px=0, py=0, n=0, miter=0, pcolour=0, in_set=0. Every strobe, plus plot_valid, busy and done, is 0.
- Cycles per pixel with immediate ready: 1 (PIX) + k+1 (ITER, where k = final n) + 1 (PLOT). Each row adds 1 (ROW) + 1 (NEXT).
- plot_valid rises the cycle after the terminating ITER cycle. It is never withdrawn before handshake.
- dp_step and dp_init are never high together.
- dp_escaped is ignored outside ITER.
- Reset asserted mid-frame returns to IDLE immediately. No plot completes after reset; a partly written frame is abandoned.
- start held high through DONE restarts immediately. A single-cycle start while busy is dropped.

## Configuration
- MANDEL_SCAN_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort=1 in any busy state, including PLOT with handshake pending, forces IDLE on the next edge.
  - plot_valid drops and done stays 0.
  - abort has priority over every transition, including a same-cycle plot handshake; that pixel counts as not written.
- Macro undefined: no abort port; a frame can only be stopped by rst.

## Structure
- mandel_pkg holds:
  - the scan_state_t enum;
  - default WIDTH/HEIGHT/ITERW localparams shared with the datapath and VGA writer.
- One sub-module, mandel_raster_ctr:
  - holds the px/py counters with clear, x_inc and y_inc strobes;
  - flags x_last and y_last.
- The FSM, n/miter registers and output decode stay in mandel_scan_ctrl.

## Test plan
- WIDTH=4, HEIGHT=2, max_iter=3, dp_escaped tied 0, plot_ready tied 1 → 8 plots in raster order (0,0)…(3,1), each pcolour=3, in_set=1; done rises 8×(1+4+1)+2×2 cycles after start accepted.
- dp_escaped asserted on the third ITER cycle of pixel (1,0), max_iter=10 → pcolour=2, in_set=0; dp_step pulsed exactly twice for that pixel.
- plot_ready held 0 for 5 cycles at pixel (2,1) → plot_valid, px=2, py=1 and pcolour stable all 5 cycles; no dp_init until the handshake.
- dp_escaped and the cap coincide with max_iter=0 → pcolour=0, in_set=0; max_iter=0 without escape → in_set=1, one ITER cycle per pixel.
- rst pulsed low mid-ITER on row 1 → next cycle state is IDLE with all outputs at reset values; a new start begins at (0,0).
- MANDEL_SCAN_ABORT_EN: abort in the same cycle as a PLOT handshake → IDLE, done=0, no further plot_valid; restart renders from (0,0).

Source files
------------

// File: rtl/mandel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mandel_pkg
// Brief    : Shared scan-controller state encoding and default frame geometry
//            for the Mandelbrot renderer (controller, datapath, VGA writer).
// Revision : 1.0 - initial release
// ============================================================================
package mandel_pkg;

    localparam int unsigned c_WIDTH_DEF  = 160;
    localparam int unsigned c_HEIGHT_DEF = 120;
    localparam int unsigned c_ITERW_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ROW  = 3'd1,
        ST_PIX  = 3'd2,
        ST_ITER = 3'd3,
        ST_PLOT = 3'd4,
        ST_NEXT = 3'd5,
        ST_DONE = 3'd6
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/mandel_raster_ctr.sv
`default_nettype none
// ============================================================================
// Module   : mandel_raster_ctr
// Brief    : px/py raster counters with clear / x_inc / y_inc strobes and
//            end-of-row / end-of-frame flags.
// Revision : 1.0 - initial release
// ============================================================================
module mandel_raster_ctr #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int XW     = $clog2(WIDTH),
    parameter int YW     = $clog2(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          x_inc,
    input  logic          y_inc,
    output logic [XW-1:0] px,
    output logic [YW-1:0] py,
    output logic          x_last,
    output logic          y_last
);

    localparam logic [XW-1:0] c_X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] c_Y_LAST = YW'(HEIGHT - 1);

    logic [XW-1:0] r_px;
    logic [YW-1:0] r_py;

    // A new row always restarts at column 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_px <= '0;
            r_py <= '0;
        end else if (clear) begin
            r_px <= '0;
            r_py <= '0;
        end else if (y_inc) begin
            r_px <= '0;
            r_py <= r_py + YW'(1);
        end else if (x_inc) begin
            r_px <= r_px + XW'(1);
        end
    end

    assign px     = r_px;
    assign py     = r_py;
    assign x_last = (r_px == c_X_LAST);
    assign y_last = (r_py == c_Y_LAST);

endmodule
`default_nettype wire

// File: rtl/mandel_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mandel_scan_ctrl
// Brief    : Raster / escape-time controller sequencing the z/c datapath and
//            presenting finished pixels over a valid/ready handshake.
//            Optional MANDEL_SCAN_ABORT_EN adds an abort input.
// Revision : 1.0 - initial release
// ============================================================================
module mandel_scan_ctrl
    import mandel_pkg::*;
#(
    parameter int WIDTH  = c_WIDTH_DEF,
    parameter int HEIGHT = c_HEIGHT_DEF,
    parameter int XW     = $clog2(WIDTH),
    parameter int YW     = $clog2(HEIGHT),
    parameter int ITERW  = c_ITERW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ITERW-1:0] max_iter,
    output logic             dp_row,
    output logic             dp_init,
    output logic             dp_step,
    input  logic             dp_escaped,
    output logic [XW-1:0]    px,
    output logic [YW-1:0]    py,
    output logic [ITERW-1:0] pcolour,
    output logic             in_set,
    output logic             plot_valid,
    input  logic             plot_ready,
    output logic             busy,
    output logic             done
`ifdef MANDEL_SCAN_ABORT_EN
    ,
    input  logic             abort
`endif
);

    scan_state_t      r_state;
    scan_state_t      w_state_nxt;
    logic [ITERW-1:0] r_n;
    logic [ITERW-1:0] r_miter;
    logic [ITERW-1:0] r_pcolour;
    logic             r_in_set;

    logic w_clear;
    logic w_x_inc;
    logic w_y_inc;
    logic w_x_last;
    logic w_y_last;
    logic w_cap;
    logic w_term;
    logic w_busy;
    logic w_abort;

    mandel_raster_ctr #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .XW     (XW),
        .YW     (YW)
    ) u_raster (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_clear),
        .x_inc  (w_x_inc),
        .y_inc  (w_y_inc),
        .px     (px),
        .py     (py),
        .x_last (w_x_last),
        .y_last (w_y_last)
    );

    assign w_busy = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_cap  = (r_n == r_miter);
    assign w_term = dp_escaped || w_cap;

`ifdef MANDEL_SCAN_ABORT_EN
    assign w_abort = abort && w_busy;
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_x_inc     = 1'b0;
        w_y_inc     = 1'b0;
        dp_row      = 1'b0;
        dp_init     = 1'b0;
        dp_step     = 1'b0;
        plot_valid  = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_ROW;
                end
            end
            ST_ROW: begin
                dp_row      = 1'b1;
                w_state_nxt = ST_PIX;
            end
            ST_PIX: begin
                dp_init     = 1'b1;
                w_state_nxt = ST_ITER;
            end
            ST_ITER: begin
                if (w_term) begin
                    w_state_nxt = ST_PLOT;
                end else begin
                    dp_step = 1'b1;
                end
            end
            ST_PLOT: begin
                plot_valid = 1'b1;
                if (plot_ready) begin
                    if (w_x_last) begin
                        w_state_nxt = ST_NEXT;
                    end else begin
                        w_x_inc     = 1'b1;
                        w_state_nxt = ST_PIX;
                    end
                end
            end
            ST_NEXT: begin
                if (w_y_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_y_inc     = 1'b1;
                    w_state_nxt = ST_ROW;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_ROW;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Abort wins over everything, including a same-cycle handshake
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
            w_x_inc     = 1'b0;
            w_y_inc     = 1'b0;
            w_clear     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_n       <= '0;
            r_miter   <= '0;
            r_pcolour <= '0;
            r_in_set  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clear) begin
                r_miter <= max_iter;
            end
            if (r_state == ST_PIX) begin
                r_n <= '0;
            end else if (dp_step) begin
                r_n <= r_n + ITERW'(1);
            end
            if ((r_state == ST_ITER) && w_term) begin
                r_pcolour <= r_n;
                r_in_set  <= !dp_escaped;
            end
        end
    end

    assign busy    = w_busy;
    assign pcolour = plot_valid ? r_pcolour : '0;
    assign in_set  = plot_valid && r_in_set;

endmodule
`default_nettype wire
